// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register.
// The stage payload is the concatenation {Instr, RD1, RD2, imm32, PC}.
// Each field is 32 bits, and Instr occupies the most significant bits.
// This package holds the LSB offset of each field, the payload width and
// the NOP payload that an empty stage presents downstream.
package pipe_pkg;

  localparam int FIELD_W   = 32;
  localparam int PC_LSB    = 0;
  localparam int IMM32_LSB = PC_LSB    + FIELD_W;
  localparam int RD2_LSB   = IMM32_LSB + FIELD_W;
  localparam int RD1_LSB   = RD2_LSB   + FIELD_W;
  localparam int INSTR_LSB = RD1_LSB   + FIELD_W;
  localparam int PAYLOAD_W = INSTR_LSB + FIELD_W;

  localparam logic [PAYLOAD_W-1:0] PIPE_NOP = '0;

  // Builds a payload from its five fields in the canonical order.
  function automatic logic [PAYLOAD_W-1:0] pack_payload(
    input logic [FIELD_W-1:0] instr,
    input logic [FIELD_W-1:0] rd1,
    input logic [FIELD_W-1:0] rd2,
    input logic [FIELD_W-1:0] imm32,
    input logic [FIELD_W-1:0] pc
  );
    return {instr, rd1, rd2, imm32, pc};
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One entry of the stage: a valid flag plus a WIDTH-bit data register.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset; clears valid only
//   clear     drops the entry; takes priority over load
//   load      captures load_data and marks the entry valid
//   load_data payload to capture
//   valid     entry holds a payload
//   data      held payload; meaningful only while valid is high
// The data register has no reset. Consumers qualify it with valid.
module pipe_entry #(
  parameter int WIDTH = 160
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (load) data <= load_data;
    if (reset || clear) valid <= 1'b0;
    else if (load)      valid <= 1'b1;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a skid entry.
// The stage accepts a new payload whenever the skid entry is empty, so
// in_ready is a registered signal with no combinational path from
// out_ready. The bubble counter records the cycles in which no payload
// is presented downstream.
// Ports:
//   clk, reset  rising-edge clock; synchronous active-high reset
//   flush       discard both entries; the in_data of this cycle is dropped
//   in_valid    upstream handshake, payload is in_data
//   in_ready    upstream handshake, stage can accept this cycle
//   in_data     upstream payload
//   out_valid   downstream handshake
//   out_ready   downstream handshake
//   out_data    downstream payload; NOP_VALUE while the stage is empty
//   bubble_cnt  saturating count of cycles with out_valid low
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PAYLOAD_W,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(PIPE_NOP),
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             accept, pop;
  logic             main_load, main_clear, skid_load, skid_clear;
  logic [WIDTH-1:0] main_next;

  // Adds one to the count and holds it once it reaches all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : NOP_VALUE;

  assign accept = in_valid && in_ready;
  assign pop    = main_valid && out_ready;

  // An accept is only possible while skid is empty. So when skid is
  // valid, the only source for the main entry is the skid entry.
  assign main_next  = skid_valid ? skid_data : in_data;
  assign main_load  = !flush && ((pop && skid_valid) ||
                                 (accept && (!main_valid || pop)));
  assign main_clear = flush || (pop && !main_load);
  assign skid_load  = !flush && accept && main_valid && !pop;
  assign skid_clear = flush || (pop && skid_valid);

  // Stage boundary: main entry drives the downstream port.
  pipe_entry #(.WIDTH(WIDTH)) u_main (
    .clk       (clk),
    .reset     (reset),
    .clear     (main_clear),
    .load      (main_load),
    .load_data (main_next),
    .valid     (main_valid),
    .data      (main_data)
  );

  // Stage boundary: skid entry absorbs the beat that arrives while main stalls.
  pipe_entry #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (skid_clear),
    .load      (skid_load),
    .load_data (in_data),
    .valid     (skid_valid),
    .data      (skid_data)
  );

  always_ff @(posedge clk) begin
    if (reset)           bubble_cnt <= '0;
    else if (!main_valid) bubble_cnt <= sat_inc(bubble_cnt);
  end

endmodule
